// File: rtl/baopoco_fft_shift_ctrl.sv
// FFT shift-schedule controller: swaps in the software schedule only on sync so a spectrum never
// sees a mid-stream change, and keeps overflow / spectrum / misalignment statistics for readback.
module baopoco_fft_shift_ctrl #(
   parameter int unsigned       STAGES        = 12,
   parameter int unsigned       SPEC_CYCLES   = 2048,
   parameter logic [STAGES-1:0] DEFAULT_SHIFT = {STAGES{1'b1}},
   parameter int unsigned       CNT_W         = 32
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       reg_word,
   input  logic              sync_in,
   input  logic              fft_of,
   output logic              sync_out,
   output logic [STAGES-1:0] shift_out,
   output logic              of_flag,
   output logic [CNT_W-1:0]  of_count,
   output logic [CNT_W-1:0]  spec_count,
   output logic              sync_err
);

   localparam int unsigned      CW       = (SPEC_CYCLES > 1) ? $clog2(SPEC_CYCLES) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(SPEC_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [0:0] {
      StWaitSync,
      StRun
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sticky_q, sticky_d;
   logic [31:0]       reg_q;
   logic              clr_q;
   logic              sync_out_q;
   logic [STAGES-1:0] shift_q, shift_d;
   logic              of_flag_q, of_flag_d;
   logic [CNT_W-1:0]  of_count_q, of_count_d;
   logic [CNT_W-1:0]  spec_count_q, spec_count_d;
   logic              sync_err_q, sync_err_d;

   logic clr_pulse;
   logic at_last;
   logic boundary;
   logic ended;
   logic unused_reg;

   assign unused_reg = ^reg_q[30:STAGES];

   // Counter clear acts on the rising edge of bit 31 only, so a held bit clears once.
   assign clr_pulse = reg_q[31] & ~clr_q;
   assign at_last   = (cnt_q == CNT_LAST);
   assign boundary  = (state_q == StRun) & (at_last | sync_in);
   // The boundary cycle's own sample still belongs to the spectrum that is ending.
   assign ended     = sticky_q | fft_of;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sticky_d     = sticky_q;
      shift_d      = shift_q;
      of_flag_d    = of_flag_q;
      of_count_d   = of_count_q;
      spec_count_d = spec_count_q;
      sync_err_d   = sync_err_q;

      if (sync_in) begin
         shift_d = reg_q[STAGES-1:0];
      end

      unique case (state_q)
         StWaitSync: begin
            if (sync_in) begin
               state_d  = StRun;
               cnt_d    = '0;
               sticky_d = 1'b0;
            end
         end
         StRun: begin
            if (boundary) begin
               cnt_d    = '0;
               sticky_d = 1'b0;
            end else begin
               cnt_d    = cnt_q + CW'(1);
               sticky_d = sticky_q | fft_of;
            end
         end
         default: state_d = StWaitSync;
      endcase

      if (boundary) begin
         of_flag_d = ended;
         if (spec_count_q != CNT_MAX) begin
            spec_count_d = spec_count_q + CNT_W'(1);
         end
         if (ended && (of_count_q != CNT_MAX)) begin
            of_count_d = of_count_q + CNT_W'(1);
         end
         if (sync_in && !at_last) begin
            sync_err_d = 1'b1;
         end
      end

      // Clear wins over any coincident update; FSM, count and schedule are left alone.
      if (clr_pulse) begin
         of_flag_d    = 1'b0;
         of_count_d   = '0;
         spec_count_d = '0;
         sync_err_d   = 1'b0;
      end
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state_q      <= StWaitSync;
         cnt_q        <= '0;
         sticky_q     <= 1'b0;
         reg_q        <= '0;
         clr_q        <= 1'b0;
         sync_out_q   <= 1'b0;
         shift_q      <= DEFAULT_SHIFT;
         of_flag_q    <= 1'b0;
         of_count_q   <= '0;
         spec_count_q <= '0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sticky_q     <= sticky_d;
         reg_q        <= reg_word;
         clr_q        <= reg_q[31];
         sync_out_q   <= sync_in;
         shift_q      <= shift_d;
         of_flag_q    <= of_flag_d;
         of_count_q   <= of_count_d;
         spec_count_q <= spec_count_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign sync_out   = sync_out_q;
   assign shift_out  = shift_q;
   assign of_flag    = of_flag_q;
   assign of_count   = of_count_q;
   assign spec_count = spec_count_q;
   assign sync_err   = sync_err_q;

endmodule
